// File: rtl/gcl_execute_sm_param.sv
// Gate-control-list executor with double-buffered ADMIN/OPER banks.
// A new list is promoted only on a CycleStart boundary, so the swap never tears a cycle.
//
// state | meaning
// IDLE  | no operational list; gates held at INIT_GATES
// RUN   | walking OPER entries; remaining counts down the current dwell
// HOLD  | last entry finished; gates and index frozen until CycleStart
module gcl_execute_sm_param #(
  parameter int NUM_QUEUES = 8,
  parameter int LIST_DEPTH = 16,
  parameter int TI_WIDTH   = 32,
  parameter int STEP_NS    = 8,
  parameter logic [NUM_QUEUES-1:0] INIT_GATES = '1,
  localparam int AW = $clog2(LIST_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CycleStart,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [NUM_QUEUES-1:0] wr_gates,
  input  logic [TI_WIDTH-1:0]   wr_interval,
  input  logic [LW-1:0]         admin_len,
  input  logic                  config_change,
  output logic [NUM_QUEUES-1:0] OutGateStates,
  output logic [AW-1:0]         cur_index,
  output logic                  running,
  output logic                  config_pending,
  output logic                  config_done,
  output logic                  wr_err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  oper_bank_q, oper_bank_d;
  logic [LW-1:0]         oper_len_q, oper_len_d;
  logic [AW-1:0]         cur_index_q, cur_index_d;
  logic [TI_WIDTH-1:0]   remaining_q, remaining_d;
  logic [NUM_QUEUES-1:0] gates_q, gates_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;

  logic [NUM_QUEUES-1:0] gates_mem [2][LIST_DEPTH];
  logic [TI_WIDTH-1:0]   ti_mem    [2][LIST_DEPTH];

  logic                  addr_ok;
  logic                  wr_ok;
  logic                  swap;
  logic                  bank_nx;
  logic [LW-1:0]         len_nx;
  logic [LW-1:0]         admin_len_clamped;
  logic [AW-1:0]         idx_inc;
  logic [LW-1:0]         next_pos;

  // With a power-of-two depth every encodable address is in range.
  generate
    if (LIST_DEPTH == (1 << AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = ({1'b0, wr_addr} < LW'(LIST_DEPTH));
    end
  endgenerate

  assign wr_ok = wr_en && !pending_q && addr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      gates_mem[~oper_bank_q][wr_addr] <= wr_gates;
      ti_mem[~oper_bank_q][wr_addr]    <= wr_interval;
    end
  end

  assign admin_len_clamped = (admin_len > LW'(LIST_DEPTH)) ? LW'(LIST_DEPTH) : admin_len;
  assign swap     = CycleStart && pending_q;
  assign bank_nx  = swap ? ~oper_bank_q : oper_bank_q;
  assign len_nx   = swap ? admin_len_clamped : oper_len_q;
  assign idx_inc  = cur_index_q + AW'(1);
  assign next_pos = {1'b0, cur_index_q} + LW'(1);

  always_comb begin
    state_d     = state_q;
    oper_bank_d = oper_bank_q;
    oper_len_d  = oper_len_q;
    cur_index_d = cur_index_q;
    remaining_d = remaining_q;
    gates_d     = gates_q;
    done_d      = 1'b0;
    wr_err_d    = wr_en && !wr_ok;

    // A request coinciding with CycleStart arms for the following boundary.
    if (swap) begin
      pending_d = 1'b0;
    end else if (config_change) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    if (CycleStart) begin
      oper_bank_d = bank_nx;
      oper_len_d  = len_nx;
      done_d      = swap;
      cur_index_d = '0;
      if (len_nx == '0) begin
        state_d     = IDLE;
        gates_d     = INIT_GATES;
        remaining_d = '0;
      end else begin
        state_d     = RUN;
        gates_d     = gates_mem[bank_nx][0];
        remaining_d = ti_mem[bank_nx][0];
      end
    end else begin
      case (state_q)
        RUN: begin
          if (remaining_q > TI_WIDTH'(STEP_NS)) begin
            remaining_d = remaining_q - TI_WIDTH'(STEP_NS);
          end else if (next_pos < oper_len_q) begin
            cur_index_d = idx_inc;
            gates_d     = gates_mem[oper_bank_q][idx_inc];
            remaining_d = ti_mem[oper_bank_q][idx_inc];
          end else begin
            state_d = HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      oper_bank_q <= 1'b0;
      oper_len_q  <= '0;
      cur_index_q <= '0;
      remaining_q <= '0;
      gates_q     <= INIT_GATES;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      oper_bank_q <= oper_bank_d;
      oper_len_q  <= oper_len_d;
      cur_index_q <= cur_index_d;
      remaining_q <= remaining_d;
      gates_q     <= gates_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign OutGateStates  = gates_q;
  assign cur_index      = cur_index_q;
  assign running        = (state_q != IDLE);
  assign config_pending = pending_q;
  assign config_done    = done_q;
  assign wr_err         = wr_err_q;

endmodule

// File: tb/tb_gcl_execute_sm_param.sv
// Bench for gcl_execute_sm_param: a per-clock vector table drives a default
// 8x16 instance and a 4x4 instance in lockstep, then an async reset check.
module tb_gcl_execute_sm_param;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        cfg;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  wg;
  logic [31:0] ti;
  logic [4:0]  len;

  logic [7:0]  g_b;
  logic [3:0]  idx_b;
  logic        run_b, pend_b, done_b, err_b;
  logic [3:0]  g_s;
  logic [1:0]  idx_s;
  logic        run_s, pend_s, done_s, err_s;

  int errors = 0;
  int checks = 0;

  gcl_execute_sm_param dut_big (
    .clk(clk), .rst_n(rst_n), .CycleStart(cs), .wr_en(we), .wr_addr(addr),
    .wr_gates(wg), .wr_interval(ti), .admin_len(len), .config_change(cfg),
    .OutGateStates(g_b), .cur_index(idx_b), .running(run_b),
    .config_pending(pend_b), .config_done(done_b), .wr_err(err_b)
  );

  gcl_execute_sm_param #(.NUM_QUEUES(4), .LIST_DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .CycleStart(cs), .wr_en(we), .wr_addr(addr[1:0]),
    .wr_gates(wg[3:0]), .wr_interval(ti), .admin_len(len[2:0]), .config_change(cfg),
    .OutGateStates(g_s), .cur_index(idx_s), .running(run_s),
    .config_pending(pend_s), .config_done(done_s), .wr_err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cs, cfg, we;
    logic [3:0]  addr;
    logic [7:0]  g;
    logic [31:0] ti;
    logic [4:0]  len;
    logic [7:0]  e_g;
    logic [3:0]  e_idx;
    logic        e_run, e_pend, e_done, e_err;
  } vec_t;

  vec_t vecs [64];
  int   nv = 0;

  task automatic add(input logic c, input logic f, input logic w, input logic [3:0] a,
                     input logic [7:0] g, input logic [31:0] t, input logic [4:0] l,
                     input logic [7:0] eg, input logic [3:0] ei, input logic er,
                     input logic ep, input logic ed, input logic ee);
    vecs[nv].cs = c;   vecs[nv].cfg = f;  vecs[nv].we = w;   vecs[nv].addr = a;
    vecs[nv].g = g;    vecs[nv].ti = t;   vecs[nv].len = l;
    vecs[nv].e_g = eg; vecs[nv].e_idx = ei; vecs[nv].e_run = er;
    vecs[nv].e_pend = ep; vecs[nv].e_done = ed; vecs[nv].e_err = ee;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [7:0] eg, input logic [3:0] ei,
                          input logic er, input logic ep, input logic ed, input logic ee);
    chk({tag, " gates"},   32'(g_b),    32'(eg));
    chk({tag, " index"},   32'(idx_b),  32'(ei));
    chk({tag, " running"}, 32'(run_b),  32'(er));
    chk({tag, " pending"}, 32'(pend_b), 32'(ep));
    chk({tag, " done"},    32'(done_b), 32'(ed));
    chk({tag, " wr_err"},  32'(err_b),  32'(ee));
    chk({tag, " s_gates"},   32'(g_s),    32'(eg[3:0]));
    chk({tag, " s_index"},   32'(idx_s),  32'(ei[1:0]));
    chk({tag, " s_running"}, 32'(run_s),  32'(er));
    chk({tag, " s_pending"}, 32'(pend_s), 32'(ep));
    chk({tag, " s_done"},    32'(done_s), 32'(ed));
    chk({tag, " s_wr_err"},  32'(err_s),  32'(ee));
  endtask

  initial begin
    //   cs cfg we addr gates  ti  len | gates idx run pend done err
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'hFF, 0, 0, 0, 0, 0); // CycleStart in IDLE, no list
    add(0, 0, 1, 0, 8'h81, 24, 0,  8'hFF, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 8'h42,  8, 0,  8'hFF, 0, 0, 0, 0, 0);
    add(0, 0, 1, 2, 8'h3C,  0, 0,  8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 3,  8'hFF, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 3,  8'h81, 0, 1, 0, 1, 0); // swap
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h42, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h3C, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h3C, 2, 1, 0, 0, 0); // HOLD
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0); // CycleStart every 2 clks
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 8'h11, 16, 0,  8'h81, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 8'h00,  0, 1,  8'h81, 0, 1, 1, 0, 0); // request with CycleStart: no swap
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h81, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 1,  8'h11, 0, 1, 0, 1, 0); // swap at following CycleStart
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h11, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h11, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h11, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 0,  8'h11, 0, 1, 1, 0, 0);
    add(0, 0, 1, 0, 8'hAA,  8, 0,  8'h11, 0, 1, 1, 0, 1); // write while pending dropped
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h11, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'hFF, 0, 0, 0, 1, 0); // swap to empty list
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'hFF, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 0,  8'hFF, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 1,  8'hFF, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 1,  8'h11, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00,  0, 1,  8'h11, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 1,  8'h81, 0, 1, 0, 1, 0); // entry 0 not overwritten by 0xAA
    add(0, 0, 1, 0, 8'h55,  8, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 8'h66, 80, 0,  8'h81, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 2,  8'h81, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 8'h00,  0, 2,  8'h55, 0, 1, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00,  0, 0,  8'h66, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00,  0, 0,  8'h66, 1, 1, 1, 0, 0);

    rst_n = 1'b0; cs = 0; cfg = 0; we = 0; addr = 0; wg = 0; ti = 0; len = 0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk_both("reset", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      cs = vecs[i].cs; cfg = vecs[i].cfg; we = vecs[i].we; addr = vecs[i].addr;
      wg = vecs[i].g;  ti = vecs[i].ti;   len = vecs[i].len;
      @(posedge clk);
      #1;
      chk_both($sformatf("row%0d", i), vecs[i].e_g, vecs[i].e_idx, vecs[i].e_run,
               vecs[i].e_pend, vecs[i].e_done, vecs[i].e_err);
    end

    @(negedge clk);
    cs = 0; cfg = 0; we = 0; len = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_both("async_reset", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_both("post_reset", 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
